// File: rtl/alu_flags_reg_if.sv
// Signal bundle between the ALU/control unit and the architectural flags register.
// The flags register connects through the slave modport; the driving side uses master.
interface alu_flags_reg_if #(
  parameter int unsigned WIDTH = 8
);
  // ALU flag capture
  logic             flag_zero_in;
  logic             flag_acarry_in;
  logic             flag_lcarry_in;
  logic             flag_sign_in;
  logic             flag_overflow_in;
  logic             update_en;
  logic [4:0]       update_mask;

  // Data bus save/restore (PUSHF/POPF)
  logic             load_bus;
  logic [WIDTH-1:0] bus_in;
  logic             assert_bus;
  logic [WIDTH-1:0] bus_out;
  logic             bus_en;

  // Interrupt shadow, carry commands, branch condition
  logic             save_shadow;
  logic             restore_shadow;
  logic [1:0]       carry_cmd;
  logic [3:0]       cond_sel;
  logic             cond_true;

  // Live flags
  logic             flag_zero;
  logic             flag_acarry;
  logic             flag_lcarry;
  logic             flag_sign;
  logic             flag_overflow;

  modport master (
    output flag_zero_in, flag_acarry_in, flag_lcarry_in, flag_sign_in, flag_overflow_in,
    output update_en, update_mask, load_bus, bus_in, assert_bus,
    output save_shadow, restore_shadow, carry_cmd, cond_sel,
    input  bus_out, bus_en, cond_true,
    input  flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow
  );

  modport slave (
    input  flag_zero_in, flag_acarry_in, flag_lcarry_in, flag_sign_in, flag_overflow_in,
    input  update_en, update_mask, load_bus, bus_in, assert_bus,
    input  save_shadow, restore_shadow, carry_cmd, cond_sel,
    output bus_out, bus_en, cond_true,
    output flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow
  );
endinterface

// File: rtl/alu_flags_reg.sv
// Architectural flags register: captures ALU flags, feeds carry back to the ALU,
// supports PUSHF/POPF over the data bus, an interrupt shadow copy and branch conditions.
module alu_flags_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_flags_reg_if.slave fb
);

  // Flag bit positions within the 5-bit register: {O,S,LC,AC,Z}
  localparam int unsigned F_Z  = 0;
  localparam int unsigned F_AC = 1;
  localparam int unsigned F_LC = 2;
  localparam int unsigned F_S  = 3;
  localparam int unsigned F_O  = 4;

  typedef enum logic [1:0] {
    CARRY_NONE  = 2'b00,
    CARRY_CLEAR = 2'b01,
    CARRY_SET   = 2'b10,
    CARRY_CPL   = 2'b11
  } carry_cmd_e;

  typedef enum logic [3:0] {
    COND_ALWAYS = 4'h0,
    COND_Z      = 4'h1,
    COND_NZ     = 4'h2,
    COND_AC     = 4'h3,
    COND_NAC    = 4'h4,
    COND_S      = 4'h5,
    COND_NS     = 4'h6,
    COND_O      = 4'h7,
    COND_NO     = 4'h8,
    COND_LC     = 4'h9,
    COND_NLC    = 4'hA,
    COND_LT     = 4'hB,
    COND_GE     = 4'hC,
    COND_LE     = 4'hD,
    COND_GT     = 4'hE,
    COND_NEVER  = 4'hF
  } cond_e;

  logic [4:0]       live_q;
  logic [4:0]       live_d;
  logic [4:0]       shadow_q;
  logic [4:0]       shadow_d;
  logic [4:0]       alu_flags;
  logic [WIDTH-1:0] bus_word;
  logic             signed_lt;
  logic             unused_bus_hi;

  assign alu_flags = {fb.flag_overflow_in, fb.flag_sign_in, fb.flag_lcarry_in,
                      fb.flag_acarry_in, fb.flag_zero_in};

  // Only bus_in[4:0] is architecturally meaningful; upper bits are ignored.
  assign unused_bus_hi = ^fb.bus_in;

  // Single-writer priority: bus load, then shadow restore, then ALU update, then carry command.
  always_comb begin
    live_d = live_q;
    if (fb.load_bus) begin
      live_d = fb.bus_in[4:0];
    end else if (fb.restore_shadow) begin
      live_d = shadow_q;
    end else if (fb.update_en) begin
      live_d = (live_q & ~fb.update_mask) | (alu_flags & fb.update_mask);
    end else begin
      unique case (carry_cmd_e'(fb.carry_cmd))
        CARRY_NONE:  live_d[F_AC] = live_q[F_AC];
        CARRY_CLEAR: live_d[F_AC] = 1'b0;
        CARRY_SET:   live_d[F_AC] = 1'b1;
        CARRY_CPL:   live_d[F_AC] = ~live_q[F_AC];
        default:     live_d[F_AC] = live_q[F_AC];
      endcase
    end
  end

  // Shadow always samples the pre-edge live value, so save+restore swaps the two.
  always_comb begin
    shadow_d = shadow_q;
    if (fb.save_shadow) begin
      shadow_d = live_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q   <= '0;
      shadow_q <= '0;
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    bus_word      = '0;
    bus_word[4:0] = live_q;
  end

  assign fb.bus_out = fb.assert_bus ? bus_word : '0;
  assign fb.bus_en  = fb.assert_bus;

  assign fb.flag_zero     = live_q[F_Z];
  assign fb.flag_acarry   = live_q[F_AC];
  assign fb.flag_lcarry   = live_q[F_LC];
  assign fb.flag_sign     = live_q[F_S];
  assign fb.flag_overflow = live_q[F_O];

  assign signed_lt = live_q[F_S] ^ live_q[F_O];

  always_comb begin
    fb.cond_true = 1'b0;
    unique case (cond_e'(fb.cond_sel))
      COND_ALWAYS: fb.cond_true = 1'b1;
      COND_Z:      fb.cond_true = live_q[F_Z];
      COND_NZ:     fb.cond_true = ~live_q[F_Z];
      COND_AC:     fb.cond_true = live_q[F_AC];
      COND_NAC:    fb.cond_true = ~live_q[F_AC];
      COND_S:      fb.cond_true = live_q[F_S];
      COND_NS:     fb.cond_true = ~live_q[F_S];
      COND_O:      fb.cond_true = live_q[F_O];
      COND_NO:     fb.cond_true = ~live_q[F_O];
      COND_LC:     fb.cond_true = live_q[F_LC];
      COND_NLC:    fb.cond_true = ~live_q[F_LC];
      COND_LT:     fb.cond_true = signed_lt;
      COND_GE:     fb.cond_true = ~signed_lt;
      COND_LE:     fb.cond_true = live_q[F_Z] | signed_lt;
      COND_GT:     fb.cond_true = ~live_q[F_Z] & ~signed_lt;
      COND_NEVER:  fb.cond_true = 1'b0;
      default:     fb.cond_true = 1'b0;
    endcase
  end

endmodule

// File: doc/alu_flags_reg.md
Name: alu_flags_reg

Overview:
- Architectural flags register that sits directly downstream of the ALU.
- Captures the ALU's five flag outputs after each flag-setting operation and feeds the stored carry back to the ALU for add-with-carry.
- Evaluates a 4-bit branch condition for the control unit.
- Supports flag save and restore through the data bus (PUSHF/POPF), a one-deep interrupt shadow copy, and explicit set/clear of the arithmetic carry.

Parameters:
WIDTH, 8, data bus width; flags occupy bits [4:0], bits [WIDTH-1:5] read as 0 (WIDTH >= 5)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
flag_zero_in  input  1  ALU zero flag
flag_acarry_in  input  1  ALU arithmetic carry
flag_lcarry_in  input  1  ALU logic/shift carry
flag_sign_in  input  1  ALU sign flag
flag_overflow_in  input  1  ALU overflow flag
update_en  input  1  capture ALU flags this cycle
update_mask  input  5  per-flag write enable for update_en; bit order {O,S,LC,AC,Z}
load_bus  input  1  load flags from bus_in[4:0] (POPF)
bus_in  input  WIDTH  data bus
assert_bus  input  1  drive flags onto bus (PUSHF)
bus_out  output  WIDTH  {0..., O,S,LC,AC,Z} when asserted, else 0
bus_en  output  1  equals assert_bus
save_shadow  input  1  copy live flags into shadow (interrupt entry)
restore_shadow  input  1  copy shadow into live flags (RETI)
carry_cmd  input  2  00 none, 01 clear AC, 10 set AC, 11 complement AC
cond_sel  input  4  condition code select
cond_true  output  1  selected condition result
flag_zero  output  1  live Z
flag_acarry  output  1  live AC; this is the ALU carry-in
flag_lcarry  output  1  live LC
flag_sign  output  1  live S
flag_overflow  output  1  live O

Behaviour:
- Reset (reset_n low, asynchronous): live flags = 0 and shadow = 0. Outputs during reset: bus_out = 0, bus_en = assert_bus, cond_true per cond_sel on zero flags.
- Live-flag write priority per edge, highest first:
  - load_bus: all five flags take bus_in[4:0]; bus_in[WIDTH-1:5] is ignored.
  - restore_shadow: all five flags take the shadow.
  - update_en: each flag whose mask bit is 1 takes its *_in value; unmasked flags hold.
  - carry_cmd: acts on AC only.
- Only the highest-priority active source writes on a given edge; lower sources are ignored that cycle. update_en with mask 0 counts as active and blocks carry_cmd.
- Shadow write: save_shadow captures the live flags as they stand before the edge. Saving and writing in the same cycle is allowed: the shadow gets the old value, the live register gets the new one. save_shadow with restore_shadow in the same cycle swaps the two.
- Write latency: one cycle. Outputs reflect a write after the capturing edge. An ADDC issued the cycle after an ADD sees the new AC.
- bus_out and bus_en are combinational from assert_bus and the live register. assert_bus together with load_bus in the same cycle drives the pre-edge value, then loads.
- cond_true is combinational from the live flags, decoded on cond_sel:
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 AC
  - 4 !AC
  - 5 S
  - 6 !S
  - 7 O
  - 8 !O
  - 9 LC
  - A !LC
  - B S^O (signed less)
  - C !(S^O) (signed greater/equal)
  - D Z|(S^O) (signed less/equal)
  - E !Z&!(S^O) (signed greater)
  - F never
- Reset asserted mid-operation clears live and shadow immediately. No capture occurs on the edge where reset_n is low.
- Minimal implementation is one 5-bit register, one 5-bit shadow, the priority mux and the condition decoder.

Test Plan:
- Reset: reset_n low mid-cycle with flags = 5'h1F -> all flag outputs 0 immediately; cond_sel=0 -> cond_true=1; cond_sel=F -> 0.
- ALU update: inputs Z=0, AC=1, LC=0, S=0, O=0 (200+64), update_en=1, mask=5'h1F -> flag_acarry=1 next cycle. Repeat with Z=1, AC=0, mask=5'h01 -> Z=1 and AC still 1, so the following ADDC sees carry 1.
- Carry commands: carry_cmd 10, 11, 01, 11 on consecutive cycles from AC=0 -> AC = 1, 0, 0, 1. update_en=1 with mask=0 and carry_cmd=10 -> AC unchanged.
- Bus path: load_bus with bus_in=8'hF5 -> flags = 5'h15, then assert_bus -> bus_out=8'h15 and bus_en=1. assert_bus low -> bus_out=0, bus_en=0. load_bus and update_en together -> the bus value wins.
- Shadow: flags=5'h0A, then save_shadow, then load 5'h11, then restore_shadow -> flags=5'h0A. save and restore in the same cycle with live=5'h03, shadow=5'h1C -> live=5'h1C, shadow=5'h03.
- Conditions: sweep cond_sel 0..F for flags S=1, O=0, Z=0 -> B=1, C=0, D=1, E=0. Same sweep for S=1, O=1 -> B=0, C=1, D=0, E=1.
